// File: rtl/armleocpu_ptw.sv
// Sv32 page-table walker: resolves a 20-bit VPN into a 22-bit PPN plus the
// leaf PTE access bits. It reads at most two PTEs over an Avalon-MM style
// read-only master port.
//
// Handshake: m_read is the request valid and stays high with m_address stable
// until a cycle where m_waitrequest is low (ready); that cycle transfers the
// request. Read data arrives later as a single beat qualified by
// m_readdatavalid, and the beat is honoured only while the walker is in WAIT.
module armleocpu_ptw (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resolve_request,
  input  logic [19:0] virtual_address,
  input  logic [21:0] satp_ppn,
  output logic        resolve_busy,
  output logic        resolve_done,
  output logic        resolve_pagefault,
  output logic        resolve_accessfault,
  output logic [21:0] resolve_physical_address,
  output logic [7:0]  resolve_access_bits,
  output logic [33:0] m_address,
  output logic [3:0]  m_burstcount,
  input  logic        m_waitrequest,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic        m_readdatavalid,
  output logic        m_write,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic        level, level_nxt;     // 1 = root table, 0 = leaf table
  logic [19:0] vpn;
  logic        load_vpn;
  logic [33:0] m_address_nxt;
  logic        done_nxt, pf_nxt, af_nxt;
  logic [21:0] phys_nxt;
  logic [7:0]  acc_nxt;
  logic [33:0] root_addr, leaf_addr;
  logic        pte_v, pte_r, pte_w, pte_x;

  // The walker never writes, so the write side is tied off.
  assign m_burstcount = 4'd1;
  assign m_write      = 1'b0;
  assign m_writedata  = 32'd0;
  assign m_byteenable = 4'hF;

  assign root_addr = {satp_ppn, virtual_address[19:10], 2'b00};
  assign leaf_addr = {m_readdata[31:10], vpn[9:0], 2'b00};
  assign pte_v     = m_readdata[0];
  assign pte_r     = m_readdata[1];
  assign pte_w     = m_readdata[2];
  assign pte_x     = m_readdata[3];

  // State and datapath registers; results only move on a successful walk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                    <= S_IDLE;
      level                    <= 1'b1;
      vpn                      <= '0;
      m_address                <= '0;
      resolve_done             <= 1'b0;
      resolve_pagefault        <= 1'b0;
      resolve_accessfault      <= 1'b0;
      resolve_physical_address <= '0;
      resolve_access_bits      <= '0;
    end else begin
      state                    <= state_nxt;
      level                    <= level_nxt;
      m_address                <= m_address_nxt;
      resolve_done             <= done_nxt;
      resolve_pagefault        <= pf_nxt;
      resolve_accessfault      <= af_nxt;
      resolve_physical_address <= phys_nxt;
      resolve_access_bits      <= acc_nxt;
      if (load_vpn) vpn <= virtual_address;
    end
  end

  // Next-state and walk decisions: accept, address check, PTE evaluation.
  always_comb begin
    state_nxt     = state;
    level_nxt     = level;
    m_address_nxt = m_address;
    load_vpn      = 1'b0;
    done_nxt      = 1'b0;
    pf_nxt        = 1'b0;
    af_nxt        = 1'b0;
    phys_nxt      = resolve_physical_address;
    acc_nxt       = resolve_access_bits;
    case (state)
      S_IDLE: begin
        // The completion cycle itself is idle but must not accept a request.
        if (resolve_request && !resolve_done) begin
          load_vpn      = 1'b1;
          level_nxt     = 1'b1;
          m_address_nxt = root_addr;
          if (root_addr[33:32] != 2'b00) begin
            done_nxt = 1'b1;
            af_nxt   = 1'b1;
          end else begin
            state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        if (!m_waitrequest) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (m_readdatavalid) begin
          state_nxt = S_IDLE;
          if (!pte_v || (!pte_r && pte_w)) begin
            done_nxt = 1'b1;
            pf_nxt   = 1'b1;
          end else if (pte_r || pte_x) begin
            done_nxt = 1'b1;
            if (level && (m_readdata[19:10] != 10'd0)) begin
              // Superpage leaf whose low PPN bits are not zero is misaligned.
              pf_nxt = 1'b1;
            end else begin
              phys_nxt = level ? {m_readdata[31:20], vpn[9:0]} : m_readdata[31:10];
              acc_nxt  = m_readdata[7:0];
            end
          end else if (level) begin
            level_nxt     = 1'b0;
            m_address_nxt = leaf_addr;
            if (leaf_addr[33:32] != 2'b00) begin
              done_nxt = 1'b1;
              af_nxt   = 1'b1;
            end else begin
              state_nxt = S_READ;
            end
          end else begin
            done_nxt = 1'b1;
            pf_nxt   = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    resolve_busy = (state != S_IDLE);
    m_read       = (state == S_READ);
  end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Bench for armleocpu_ptw: a vector table of walks replayed against a small
// memory responder, plus hand-written reset and abort sequences.
`timescale 1ns/1ps
module tb_armleocpu_ptw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        resolve_request;
  logic [19:0] virtual_address;
  logic [21:0] satp_ppn;
  logic        resolve_busy;
  logic        resolve_done;
  logic        resolve_pagefault;
  logic        resolve_accessfault;
  logic [21:0] resolve_physical_address;
  logic [7:0]  resolve_access_bits;
  logic [33:0] m_address;
  logic [3:0]  m_burstcount;
  logic        m_waitrequest;
  logic        m_read;
  logic [31:0] m_readdata;
  logic        m_readdatavalid;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;

  armleocpu_ptw dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .resolve_request          (resolve_request),
    .virtual_address          (virtual_address),
    .satp_ppn                 (satp_ppn),
    .resolve_busy             (resolve_busy),
    .resolve_done             (resolve_done),
    .resolve_pagefault        (resolve_pagefault),
    .resolve_accessfault      (resolve_accessfault),
    .resolve_physical_address (resolve_physical_address),
    .resolve_access_bits      (resolve_access_bits),
    .m_address                (m_address),
    .m_burstcount             (m_burstcount),
    .m_waitrequest            (m_waitrequest),
    .m_read                   (m_read),
    .m_readdata               (m_readdata),
    .m_readdatavalid          (m_readdatavalid),
    .m_write                  (m_write),
    .m_writedata              (m_writedata),
    .m_byteenable             (m_byteenable)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: actual=no_finish required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [21:0] satp;
    logic [19:0] va;
    logic [1:0]  nreads;
    logic [31:0] pte1;
    logic [31:0] pte2;
    logic [33:0] addr1;
    logic [33:0] addr2;
    logic        pf;
    logic        af;
    logic [21:0] phys;
    logic [7:0]  acc;
    logic [7:0]  lat;
    logic [3:0]  stalls;
    logic        poke;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Scoreboard: {pagefault, accessfault, access_bits, physical}
  logic [31:0] exp_q[$];
  logic [33:0] addr_q[$];
  logic [21:0] held_phys = '0;
  logic [7:0]  held_acc  = '0;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [21:0] satp, input logic [19:0] va,
                              input logic [1:0] nreads, input logic [31:0] pte1,
                              input logic [31:0] pte2, input logic [33:0] addr1,
                              input logic [33:0] addr2, input logic pf, input logic af,
                              input logic [21:0] phys, input logic [7:0] acc,
                              input logic [7:0] lat, input logic [3:0] stalls,
                              input logic poke);
    vec_t v;
    v.satp = satp; v.va = va; v.nreads = nreads; v.pte1 = pte1; v.pte2 = pte2;
    v.addr1 = addr1; v.addr2 = addr2; v.pf = pf; v.af = af; v.phys = phys;
    v.acc = acc; v.lat = lat; v.stalls = stalls; v.poke = poke;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: actual=event required=no_event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_done"}, resolve_done, 1'b0);
    check({tag, "_busy"}, resolve_busy, 1'b0);
    check({tag, "_read"}, m_read, 1'b0);
    check({tag, "_pf"}, resolve_pagefault, 1'b0);
    check({tag, "_af"}, resolve_accessfault, 1'b0);
    check({tag, "_phys"}, resolve_physical_address, 22'd0);
    check({tag, "_acc"}, resolve_access_bits, 8'd0);
    check({tag, "_addr"}, m_address, 34'd0);
  endtask

  // Driver plus memory responder for one walk; data returns the cycle after
  // the read is accepted.
  task automatic run_walk(input vec_t v);
    logic [31:0] ptes[2];
    logic [33:0] cur_addr;
    logic [31:0] got;
    int          rd_idx;
    int          stall_left;
    bit          pending;
    bit          in_read;
    bit          done_seen;
    ptes[0] = v.pte1;
    ptes[1] = v.pte2;
    rd_idx = 0; stall_left = int'(v.stalls); pending = 0; in_read = 0; done_seen = 0;
    cur_addr = '0;
    if (v.nreads >= 2'd1) addr_q.push_back(v.addr1);
    if (v.nreads >= 2'd2) addr_q.push_back(v.addr2);
    if (!v.pf && !v.af) begin
      held_phys = v.phys;
      held_acc  = v.acc;
    end
    exp_q.push_back({v.pf, v.af, held_acc, held_phys});
    resolve_request = 1'b1;
    satp_ppn        = v.satp;
    virtual_address = v.va;
    tick();
    resolve_request = 1'b0;
    satp_ppn        = '0;
    virtual_address = '0;
    for (int cyc = 1; cyc <= 60 && !done_seen; cyc++) begin
      m_readdatavalid = pending;
      m_readdata      = (pending && rd_idx >= 1 && rd_idx <= 2) ? ptes[rd_idx-1] : $urandom;
      pending         = 0;
      m_waitrequest   = 1'b0;
      resolve_request = v.poke && (cyc == 2);
      virtual_address = v.poke ? 20'($urandom) : 20'd0;
      if (resolve_done) begin
        done_seen = 1;
        check("latency", cyc, v.lat);
        if (exp_q.size() == 0) fail("result_without_expectation");
        else begin
          got = exp_q.pop_front();
          check("result", {resolve_pagefault, resolve_accessfault,
                           resolve_access_bits, resolve_physical_address}, got);
        end
        check("busy_at_done", resolve_busy, 1'b0);
        check("reads_issued", rd_idx, v.nreads);
      end else begin
        check("busy", resolve_busy, 1'b1);
        if (m_read) begin
          if (!in_read) begin
            in_read = 1;
            if (addr_q.size() == 0) begin
              fail("unexpected_read");
              cur_addr = m_address;
            end else begin
              cur_addr = addr_q.pop_front();
              check("read_addr", m_address, cur_addr);
            end
          end else begin
            check("addr_stable", m_address, cur_addr);
          end
          if (stall_left > 0) begin
            m_waitrequest = 1'b1;
            stall_left--;
          end else begin
            pending = 1;
            rd_idx++;
            in_read = 0;
          end
        end
      end
      tick();
    end
    m_readdatavalid = 1'b0;
    m_waitrequest   = 1'b0;
    resolve_request = 1'b0;
    virtual_address = '0;
    if (!done_seen) begin
      total++;
      bad++;
      $display("FAIL timeout: actual=no_done required=done");
      exp_q.delete();
    end
    addr_q.delete();
    check("idle_after_walk", resolve_busy, 1'b0);
  endtask

  initial begin
    vec_t rv;
    logic [21:0] ppn1, ppn2;
    rst_n = 1'b0; resolve_request = 1'b0; virtual_address = '0; satp_ppn = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;

    // Directed vectors
    vecs[0] = mk(22'h00010, 20'h12345, 2'd2, 32'h00008001, 32'h002AF0CF,
                 34'h10120, 34'h20D14, 0, 0, 22'h00ABC, 8'hCF, 8'd5, 4'd0, 0);
    vecs[1] = mk(22'h00010, 20'h12345, 2'd1, 32'h1230000F, 32'h0,
                 34'h10120, 34'h0, 0, 0, 22'h48F45, 8'h0F, 8'd3, 4'd0, 0);
    vecs[2] = mk(22'h00010, 20'h12345, 2'd1, 32'h1230040F, 32'h0,
                 34'h10120, 34'h0, 1, 0, 22'h0, 8'h0, 8'd3, 4'd0, 0);
    vecs[3] = mk(22'h00010, 20'h12345, 2'd1, 32'h00000000, 32'h0,
                 34'h10120, 34'h0, 1, 0, 22'h0, 8'h0, 8'd3, 4'd0, 0);
    vecs[4] = mk(22'h00010, 20'h12345, 2'd1, 32'h00000005, 32'h0,
                 34'h10120, 34'h0, 1, 0, 22'h0, 8'h0, 8'd3, 4'd0, 0);
    vecs[5] = mk(22'h00010, 20'h12345, 2'd2, 32'h00008001, 32'h00000001,
                 34'h10120, 34'h20D14, 1, 0, 22'h0, 8'h0, 8'd5, 4'd0, 0);
    vecs[6] = mk(22'h300000, 20'h12345, 2'd0, 32'h0, 32'h0,
                 34'h0, 34'h0, 0, 1, 22'h0, 8'h0, 8'd1, 4'd0, 0);
    vecs[7] = mk(22'h00010, 20'h12345, 2'd1, 32'hC0000001, 32'h0,
                 34'h10120, 34'h0, 0, 1, 22'h0, 8'h0, 8'd3, 4'd0, 0);
    vecs[8] = mk(22'h00010, 20'h12345, 2'd2, 32'h00008001, 32'h002AF0CF,
                 34'h10120, 34'h20D14, 0, 0, 22'h00ABC, 8'hCF, 8'd8, 4'd3, 1);

    // Reset state
    tick(); tick();
    check_quiet_outputs("reset");
    check("burstcount", m_burstcount, 4'd1);
    check("write", m_write, 1'b0);
    check("writedata", m_writedata, 32'd0);
    check("byteenable", m_byteenable, 4'hF);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) run_walk(vecs[i]);

    // Random two-level walks
    for (int i = 0; i < 4; i++) begin
      ppn1 = 22'($urandom_range(0, 32'hFFFFF));
      ppn2 = 22'($urandom_range(0, 32'h3FFFFF));
      rv = mk(22'($urandom_range(0, 32'hFFFFF)), 20'($urandom), 2'd2, 32'h0, 32'h0,
              34'h0, 34'h0, 0, 0, ppn2, 8'hCB, 8'd5, 4'd0, 0);
      rv.pte1  = {ppn1, 10'h001};
      rv.pte2  = {ppn2, 10'h0CB};
      rv.addr1 = {rv.satp, rv.va[19:10], 2'b00};
      rv.addr2 = {ppn1, rv.va[9:0], 2'b00};
      run_walk(rv);
    end

    // Reset during WAIT, then a late read beat that must be ignored
    resolve_request = 1'b1; satp_ppn = 22'h00010; virtual_address = 20'h12345;
    tick();
    resolve_request = 1'b0;
    check("abort_read", m_read, 1'b1);
    tick();
    check("abort_in_wait", m_read, 1'b0);
    rst_n = 1'b0;
    tick();
    check_quiet_outputs("abort");
    rst_n = 1'b1;
    m_readdatavalid = 1'b1; m_readdata = 32'h1230000F;
    tick();
    m_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("late_beat_done", resolve_done, 1'b0);
      check("late_beat_busy", resolve_busy, 1'b0);
      tick();
    end
    held_phys = '0;
    held_acc  = '0;
    run_walk(vecs[1]);
    run_walk(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
